// File: rtl/half_adder.sv
// Parameterizable bank of independent half adders with a valid-qualified
// fixed-latency output pipeline and a saturating carry accumulator.
module half_adder #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               A,
    input  logic [WIDTH-1:0]               B,
    input  logic                           clear,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               SUM,
    output logic [WIDTH-1:0]               CARRY,
    output logic [$clog2(WIDTH+1)-1:0]     carry_count,
    output logic [CNT_W-1:0]               total_carries
);

    localparam int unsigned CC_W  = $clog2(WIDTH + 1);
    localparam int unsigned SAT_W = CNT_W + 1;

    logic [PIPE_STAGES-1:0] vld_q;
    logic [WIDTH-1:0]       sum_q   [PIPE_STAGES];
    logic [WIDTH-1:0]       carry_q [PIPE_STAGES];
    logic [CC_W-1:0]        cnt_q   [PIPE_STAGES];
    logic [CNT_W-1:0]       total_q;
    logic [CNT_W-1:0]       total_d;

    logic [WIDTH-1:0]       sum_c;
    logic [WIDTH-1:0]       carry_c;
    logic [CC_W-1:0]        cnt_c;
    logic [SAT_W-1:0]       acc_c;

    // Per-lane half add and popcount of the generate terms, ahead of stage 0
    always_comb begin
        sum_c   = A ^ B;
        carry_c = A & B;
        cnt_c   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_c = cnt_c + CC_W'(carry_c[i]);
        end
    end

    // Valid shifts every cycle; data registers load only behind a valid bit so bubbles hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                sum_q[s]   <= '0;
                carry_q[s] <= '0;
                cnt_q[s]   <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                sum_q[0]   <= sum_c;
                carry_q[0] <= carry_c;
                cnt_q[0]   <= cnt_c;
            end
            for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    sum_q[s]   <= sum_q[s-1];
                    carry_q[s] <= carry_q[s-1];
                    cnt_q[s]   <= cnt_q[s-1];
                end
            end
        end
    end

    // Saturating accumulate of presented results; clear wins over a same-cycle count
    always_comb begin
        total_d = total_q;
        acc_c   = SAT_W'(total_q) + SAT_W'(cnt_q[PIPE_STAGES-1]);
        if (clear) begin
            total_d = '0;
        end else if (vld_q[PIPE_STAGES-1]) begin
            total_d = acc_c[CNT_W] ? '1 : acc_c[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign out_valid     = vld_q[PIPE_STAGES-1];
    assign SUM           = sum_q[PIPE_STAGES-1];
    assign CARRY         = carry_q[PIPE_STAGES-1];
    assign carry_count   = cnt_q[PIPE_STAGES-1];
    assign total_carries = total_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a 1-lane single-stage instance with a 4-bit
// accumulator and an 8-lane three-stage instance with a 16-bit accumulator.
module tb_half_adder;

    logic clk;
    logic rst_n;

    // Instance A: WIDTH=1, PIPE_STAGES=1, CNT_W=4
    logic       a_vld, a_a, a_b, a_clr;
    logic       a_ov, a_sum, a_car, a_cnt;
    logic [3:0] a_tot;

    // Instance B: WIDTH=8, PIPE_STAGES=3, CNT_W=16
    logic        b_vld, b_clr;
    logic [7:0]  b_a, b_b;
    logic        b_ov;
    logic [7:0]  b_sum, b_car;
    logic [3:0]  b_cnt;
    logic [15:0] b_tot;

    int n_checks = 0;
    int n_errors = 0;

    half_adder #(.WIDTH(1), .PIPE_STAGES(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .A(a_a), .B(a_b), .clear(a_clr),
        .out_valid(a_ov), .SUM(a_sum), .CARRY(a_car), .carry_count(a_cnt),
        .total_carries(a_tot)
    );

    half_adder #(.WIDTH(8), .PIPE_STAGES(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .A(b_a), .B(b_b), .clear(b_clr),
        .out_valid(b_ov), .SUM(b_sum), .CARRY(b_car), .carry_count(b_cnt),
        .total_carries(b_tot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b_out(input string tag, input logic ov, input logic [7:0] s,
                               input logic [7:0] c, input logic [3:0] n);
        check({tag, ".ov"},  64'(b_ov),  64'(ov));
        check({tag, ".sum"}, 64'(b_sum), 64'(s));
        check({tag, ".car"}, 64'(b_car), 64'(c));
        check({tag, ".cnt"}, 64'(b_cnt), 64'(n));
    endtask

    logic       tt_a   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       tt_b   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       tt_sum [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       tt_car [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Valid pattern 1,0,1,1 then idle; the bubble and idle slots carry all-ones data
    logic       pv_vld [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] pv_a   [8] = '{8'h01, 8'hFF, 8'h0F, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] pv_b   [8] = '{8'h03, 8'hFF, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic       pe_ov  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] pe_sum [8] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h05, 8'h55, 8'h55, 8'h55};
    logic [7:0] pe_car [8] = '{8'hFF, 8'hFF, 8'h01, 8'h01, 8'h0A, 8'hAA, 8'hAA, 8'hAA};
    logic [3:0] pe_cnt [8] = '{4'd8, 4'd8, 4'd1, 4'd1, 4'd2, 4'd4, 4'd4, 4'd4};

    initial begin
        rst_n = 1'b0;
        a_vld = 1'b0; a_a = 1'b0; a_b = 1'b0; a_clr = 1'b0;
        b_vld = 1'b0; b_a = '0;   b_b = '0;   b_clr = 1'b0;
        step();
        step();
        check("rst.a_ov",  64'(a_ov),  64'd0);
        check("rst.a_tot", 64'(a_tot), 64'd0);
        check_b_out("rst.b", 1'b0, 8'h00, 8'h00, 4'd0);
        check("rst.b_tot", 64'(b_tot), 64'd0);
        rst_n = 1'b1;

        // Truth table on the single-lane, single-stage instance
        for (int i = 0; i < 4; i++) begin
            a_vld = 1'b1; a_a = tt_a[i]; a_b = tt_b[i];
            step();
            check($sformatf("tt%0d.ov", i),  64'(a_ov),  64'd1);
            check($sformatf("tt%0d.sum", i), 64'(a_sum), 64'(tt_sum[i]));
            check($sformatf("tt%0d.car", i), 64'(a_car), 64'(tt_car[i]));
            check($sformatf("tt%0d.cnt", i), 64'(a_cnt), 64'(tt_car[i]));
        end
        a_vld = 1'b0; a_a = 1'b1; a_b = 1'b1;
        step();
        check("tt.idle_ov", 64'(a_ov),  64'd0);
        check("tt.hold_sum", 64'(a_sum), 64'd0);
        check("tt.hold_car", 64'(a_car), 64'd1);
        check("tt.total",   64'(a_tot), 64'd1);

        // Saturation at 15, then clear coincident with a presented carry
        a_clr = 1'b1;
        step();
        check("sat.cleared", 64'(a_tot), 64'd0);
        a_clr = 1'b0; a_vld = 1'b1; a_a = 1'b1; a_b = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat.stop15", 64'(a_tot), 64'd15);
        step();
        check("sat.hold15", 64'(a_tot), 64'd15);
        check("sat.ov", 64'(a_ov), 64'd1);
        a_clr = 1'b1;
        step();
        check("clr.priority", 64'(a_tot), 64'd0);
        a_clr = 1'b0; a_vld = 1'b0;
        step();
        check("clr.next_add", 64'(a_tot), 64'd1);

        // Multi-lane on the 8-lane, three-stage instance
        b_vld = 1'b1; b_a = 8'hF0; b_b = 8'hCC;
        step();
        b_a = 8'hFF; b_b = 8'hFF;
        step();
        b_vld = 1'b0; b_a = 8'h00; b_b = 8'h00;
        step();
        check_b_out("ml0", 1'b1, 8'h3C, 8'hC0, 4'd2);
        step();
        check_b_out("ml1", 1'b1, 8'h00, 8'hFF, 4'd8);
        check("ml.tot2", 64'(b_tot), 64'd2);
        step();
        check("ml.idle_ov", 64'(b_ov), 64'd0);
        check("ml.tot10", 64'(b_tot), 64'd10);

        // Valid pattern with a bubble through three stages
        for (int k = 0; k < 8; k++) begin
            b_vld = pv_vld[k]; b_a = pv_a[k]; b_b = pv_b[k];
            step();
            check_b_out($sformatf("pipe%0d", k), pe_ov[k], pe_sum[k], pe_car[k], pe_cnt[k]);
        end
        check("pipe.tot17", 64'(b_tot), 64'd17);

        // Asynchronous reset with data in flight
        b_vld = 1'b1; b_a = 8'hFF; b_b = 8'h0F;
        step();
        step();
        step();
        check_b_out("pre_rst", 1'b1, 8'hF0, 8'h0F, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_b_out("arst.b", 1'b0, 8'h00, 8'h00, 4'd0);
        check("arst.b_tot", 64'(b_tot), 64'd0);
        check("arst.a_tot", 64'(a_tot), 64'd0);
        b_vld = 1'b0; b_a = 8'h00; b_b = 8'h00;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst%0d.ov", i), 64'(b_ov), 64'd0);
        end
        b_vld = 1'b1; b_a = 8'h3C; b_b = 8'h0F;
        step();
        b_vld = 1'b0; b_a = 8'h00; b_b = 8'h00;
        step();
        check("post_rst.lat", 64'(b_ov), 64'd0);
        step();
        check_b_out("post_rst.res", 1'b1, 8'h33, 8'h0C, 4'd2);
        step();
        check("post_rst.tot", 64'(b_tot), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
